// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle for decode_stage.
// The master side is the surrounding pipeline; the slave side is the decode stage.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [31:0] out_imm;
  logic [3:0]  out_class;
  logic        out_reg_write;
  logic        out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7b5, out_imm, out_class, out_reg_write, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7b5, out_imm, out_class, out_reg_write, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Single-register RV32I decode stage with valid/ready handshake and flush.
// Optional macro ILLEGAL_TRAP_EN: flag unsupported opcodes via out_illegal instead of decoding them as NOP.
module decode_stage (
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    logic signed [11:0] f;
    logic signed [31:0] r;
    f = ins[31:20];
    r = f;
    return r;
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    logic signed [11:0] f;
    logic signed [31:0] r;
    f = {ins[31:25], ins[11:7]};
    r = f;
    return r;
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    logic signed [12:0] f;
    logic signed [31:0] r;
    f = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    r = f;
    return r;
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
    logic signed [31:0] r;
    r = {ins[31:12], 12'b0};
    return r;
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
    logic signed [20:0] f;
    logic signed [31:0] r;
    f = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    r = f;
    return r;
  endfunction

  logic [6:0]         opcode;
  logic [4:0]         dec_rd;
  logic signed [31:0] dec_imm;
  logic [3:0]         dec_class;
  logic               dec_wr;
  logic               dec_known;
  logic               dec_illegal;
  logic               accept;
  logic               load;

  logic               vld_p1;
  logic [31:0]        pc_p1;
  logic [4:0]         rd_p1;
  logic [4:0]         rs1_p1;
  logic [4:0]         rs2_p1;
  logic [2:0]         funct3_p1;
  logic               funct7b5_p1;
  logic signed [31:0] imm_p1;
  logic [3:0]         class_p1;
  logic               reg_write_p1;
  logic               illegal_p1;

  assign opcode = bus.in_instr[6:0];
  assign dec_rd = bus.in_instr[11:7];

  always_comb begin
    dec_imm   = '0;
    dec_class = 4'b0000;
    dec_wr    = 1'b0;
    dec_known = 1'b1;
    case (opcode)
      OP_OP:     dec_wr = 1'b1;
      OP_IMM:    begin dec_imm = imm_i(bus.in_instr); dec_wr = 1'b1; end
      OP_LOAD:   begin dec_imm = imm_i(bus.in_instr); dec_wr = 1'b1; dec_class = 4'b0001; end
      OP_STORE:  begin dec_imm = imm_s(bus.in_instr); dec_class = 4'b0010; end
      OP_BRANCH: begin dec_imm = imm_b(bus.in_instr); dec_class = 4'b0100; end
      OP_LUI,
      OP_AUIPC:  begin dec_imm = imm_u(bus.in_instr); dec_wr = 1'b1; end
      OP_JAL:    begin dec_imm = imm_j(bus.in_instr); dec_wr = 1'b1; dec_class = 4'b1000; end
      OP_JALR:   begin dec_imm = imm_i(bus.in_instr); dec_wr = 1'b1; dec_class = 4'b1000; end
      default:   dec_known = 1'b0;
    endcase
    // Writes to x0 are architecturally discarded, so never request them.
    if (dec_rd == 5'd0)
      dec_wr = 1'b0;
  end

`ifdef ILLEGAL_TRAP_EN
  assign dec_illegal = !dec_known;
`else
  assign dec_illegal = 1'b0;
`endif

  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // An all-zero word is the fetch reset bubble: consumed but never emitted.
  assign load         = accept && !bus.flush && (bus.in_instr != 32'h0);

  // ---- stage p1: decoded bundle register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rd_p1        <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      funct3_p1    <= '0;
      funct7b5_p1  <= 1'b0;
      imm_p1       <= '0;
      class_p1     <= '0;
      reg_write_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
    end else begin
      if (bus.flush)
        vld_p1 <= 1'b0;
      else if (accept)
        vld_p1 <= load;
      else if (bus.out_ready)
        vld_p1 <= 1'b0;

      if (load) begin
        pc_p1        <= bus.in_pc;
        rd_p1        <= dec_rd;
        rs1_p1       <= bus.in_instr[19:15];
        rs2_p1       <= bus.in_instr[24:20];
        funct3_p1    <= bus.in_instr[14:12];
        funct7b5_p1  <= bus.in_instr[30];
        imm_p1       <= dec_imm;
        class_p1     <= dec_class;
        reg_write_p1 <= dec_wr;
        illegal_p1   <= dec_illegal;
      end
    end
  end

  assign bus.out_valid     = vld_p1;
  assign bus.out_pc        = pc_p1;
  assign bus.out_rd        = rd_p1;
  assign bus.out_rs1       = rs1_p1;
  assign bus.out_rs2       = rs2_p1;
  assign bus.out_funct3    = funct3_p1;
  assign bus.out_funct7b5  = funct7b5_p1;
  assign bus.out_imm       = imm_p1;
  assign bus.out_class     = class_p1;
  assign bus.out_reg_write = reg_write_p1;
  assign bus.out_illegal   = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode table plus stall, flush, bubble and reset sequences.
module tb_decode_stage;

`ifdef ILLEGAL_TRAP_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t vecs[13];
  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    //           pc          instr         rd  rs1 rs2 f3 f7 imm           cls      rw ill
    vecs[0]  = '{32'h10, 32'hFFF00293, 5,  0,  31, 0, 1, 32'hFFFFFFFF, 4'b0000, 1, 0};
    vecs[1]  = '{32'h14, 32'hFE208CE3, 25, 1,  2,  0, 1, 32'hFFFFFFF8, 4'b0100, 0, 0};
    vecs[2]  = '{32'h18, 32'h0000006F, 0,  0,  0,  0, 0, 32'h00000000, 4'b1000, 0, 0};
    vecs[3]  = '{32'h1C, 32'h12345537, 10, 8,  3,  5, 0, 32'h12345000, 4'b0000, 1, 0};
    vecs[4]  = '{32'h20, 32'hFE20AE23, 28, 1,  2,  2, 1, 32'hFFFFFFFC, 4'b0010, 0, 0};
    vecs[5]  = '{32'h24, 32'h0081A003, 0,  3,  8,  2, 0, 32'h00000008, 4'b0001, 0, 0};
    vecs[6]  = '{32'h28, 32'h002081B3, 3,  1,  2,  0, 0, 32'h00000000, 4'b0000, 1, 0};
    vecs[7]  = '{32'h2C, 32'h000280E7, 1,  5,  0,  0, 0, 32'h00000000, 4'b1000, 1, 0};
    vecs[8]  = '{32'h30, 32'h002000EF, 1,  0,  2,  0, 0, 32'h00000002, 4'b1000, 1, 0};
    vecs[9]  = '{32'h34, 32'hFFDFF06F, 0,  31, 29, 7, 1, 32'hFFFFFFFC, 4'b1000, 0, 0};
    vecs[10] = '{32'h38, 32'hFFFFF397, 7,  31, 31, 7, 1, 32'hFFFFF000, 4'b0000, 1, 0};
    vecs[11] = '{32'h3C, 32'h7FF00093, 1,  0,  31, 0, 1, 32'h000007FF, 4'b0000, 1, 0};
    vecs[12] = '{32'h40, 32'h0000007F, 0,  0,  0,  0, 0, 32'h00000000, 4'b0000, 0, ILL_EN};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_imm", bus.out_imm, 32'h0);
    chk("rst_out_class", 32'(bus.out_class), 32'd0);
    chk("rst_out_reg_write", 32'(bus.out_reg_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Decode table, back to back with out_ready high
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pc    = vecs[i].pc;
      bus.in_instr = vecs[i].instr;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].pc);
      chk($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(bus.out_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(bus.out_rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_funct3", i), 32'(bus.out_funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d_funct7b5", i), 32'(bus.out_funct7b5), 32'(vecs[i].f7b5));
      chk($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
      chk($sformatf("v%0d_class", i), 32'(bus.out_class), 32'(vecs[i].cls));
      chk($sformatf("v%0d_reg_write", i), 32'(bus.out_reg_write), 32'(vecs[i].rw));
      chk($sformatf("v%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].ill));
    end

    // Drain with no new input
    @(negedge clk);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Stall: bundle held 3 cycles while the next instruction waits
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h100;
    bus.in_instr = 32'h7FF00093;
    tick();
    chk("stall_first_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_pc     = 32'h104;
    bus.in_instr  = 32'h12345537;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_pc", k), bus.out_pc, 32'h100);
      chk($sformatf("stall%0d_imm", k), bus.out_imm, 32'h000007FF);
      chk($sformatf("stall%0d_rd", k), 32'(bus.out_rd), 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("unstall_valid", 32'(bus.out_valid), 32'd1);
    chk("unstall_pc", bus.out_pc, 32'h104);
    chk("unstall_imm", bus.out_imm, 32'h12345000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tick();
    chk("unstall_drain", 32'(bus.out_valid), 32'd0);

    // Flush drops both the held and the incoming instruction
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h200;
    bus.in_instr = 32'h002081B3;
    tick();
    chk("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.in_pc    = 32'h204;
    bus.in_instr = 32'hFFF00293;
    bus.flush    = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("flush_after_valid", 32'(bus.out_valid), 32'd0);

    // Fetch reset bubble is swallowed
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h300;
    bus.in_instr = 32'h0;
    tick();
    chk("bubble_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_instr = 32'h0000006F;
    tick();
    chk("bubble_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bubble_next_pc", bus.out_pc, 32'h300);
    chk("bubble_next_class", 32'(bus.out_class), 32'b1000);

    // Reset in the middle of a stall
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_pc     = 32'h400;
    bus.in_instr  = 32'hFFF00293;
    tick();
    chk("rstall_held_pc", bus.out_pc, 32'h300);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstall_valid", 32'(bus.out_valid), 32'd0);
    chk("rstall_pc", bus.out_pc, 32'h0);
    chk("rstall_class", 32'(bus.out_class), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rstall_accept_valid", 32'(bus.out_valid), 32'd1);
    chk("rstall_accept_pc", bus.out_pc, 32'h400);
    chk("rstall_accept_imm", bus.out_imm, 32'hFFFFFFFF);

    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("final_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 in_valid  input  1  fetch stage presents an instruction.
REQ-004 in_ready  output  1  stage accepts an instruction this cycle.
REQ-005 in_pc  input  32  PC of the presented instruction.
REQ-006 in_instr  input  32  raw RV32I instruction word.
REQ-007 flush  input  1  branch/jump redirect; discards held and incoming instructions.
REQ-008 out_valid  output  1  decoded bundle valid.
REQ-009 out_ready  input  1  execute stage consumes the bundle.
REQ-010 out_pc  output  32  PC of the held instruction.
REQ-011 out_rd, out_rs1, out_rs2  output  5 each  register indices in_instr[11:7], [19:15], [24:20].
REQ-012 out_funct3  output  3  in_instr[14:12]; out_funct7b5  output  1  in_instr[30].
REQ-013 out_imm  output  32  sign-extended immediate.
REQ-014 out_class  output  4  one-hot-or-zero {is_jump, is_branch, is_store, is_load}.
REQ-015 out_reg_write  output  1  instruction writes rd and rd != 0.
REQ-016 out_illegal  output  1  unsupported opcode flag (see Configuration).

Function
REQ-017 Single registered stage; 1-cycle latency from accept to out_valid.
REQ-018 in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
REQ-019 On accept without flush: capture in_pc and decoded fields; out_valid <= 1.
REQ-020 out_valid && out_ready && !accept: out_valid <= 0.
REQ-021 out_valid && !out_ready: all outputs hold stable; no input accepted.
REQ-022 flush: out_valid <= 0 next edge; instruction accepted same cycle dropped; flush dominates accept.
REQ-023 Accepted in_instr == 32'h0000_0000 (fetch reset bubble): out_valid <= 0, no bundle emitted.
REQ-024 Immediates: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],1'b0}); U = {[31:12],12'b0}; J = sext({[31],[19:12],[20],[30:21],1'b0}).
REQ-025 Format by opcode[6:0]: 0010011/0000011/1100111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; 0110011 imm = 0.
REQ-026 out_class: 1101111/1100111 jump; 1100011 branch; 0100011 store; 0000011 load; else 0.
REQ-027 out_reg_write = 1 for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111 when rd != 0; else 0.
REQ-028 Back-to-back accepts at full throughput when out_ready held high.

Reset
REQ-029 During reset: out_valid = 0; out_pc, out_imm = 32'h0; all other outputs 0; in_ready = 1 after release.
REQ-030 Reset mid-stall discards held bundle; first post-reset edge with in_valid accepts normally.

Configuration
REQ-031 ILLEGAL_TRAP_EN defined: opcode outside REQ-025 list (excluding all-zero bubble) emits bundle with out_illegal = 1, out_reg_write = 0, out_class = 0.
REQ-032 ILLEGAL_TRAP_EN undefined: out_illegal tied 0; unsupported opcodes emit bundle decoded as NOP (reg_write 0, class 0, imm 0).

Verification
REQ-033 addi x5,x0,-1 (32'hFFF00293) at pc 0x10, out_ready=1 -> next cycle out_valid=1, out_rd=5, out_imm=32'hFFFFFFFF, out_reg_write=1.
REQ-034 beq x1,x2,-8 (32'hFE208CE3) -> out_imm=32'hFFFFFFF8, out_class=4'b0100, out_reg_write=0.
REQ-035 Bundle held with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction accepted same cycle.
REQ-036 flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0; neither instruction emitted.
REQ-037 in_instr=32'h0 with in_valid=1 -> out_valid stays 0; jal x0,0 (32'h0000006F) -> out_class=4'b1000, out_reg_write=0.
REQ-038 ILLEGAL_TRAP_EN defined, in_instr=32'h0000007F -> out_valid=1, out_illegal=1; undefined -> out_illegal=0, out_reg_write=0.
